// File: rtl/ram_access_ctrl.sv
// Sequencer for a 16x4 synchronous RAM: single-word write, full clear and full
// scan with streamed read-back and a running sum of the scanned words.
module ram_access_ctrl #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 4,
   parameter int DEPTH  = 16,
   parameter int SUM_W  = 8
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              clr_req,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              scan_req,
   input  logic [DATA_W-1:0] ram_q,
   output logic [DATA_W-1:0] ram_data,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic              busy,
   output logic              rd_valid,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic [SUM_W-1:0]  sum,
   output logic              done
);

   typedef enum logic [2:0] {IDLE, WRITE, CLEAR, SCAN, DRAIN} state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] PENULT_ADDR = ADDR_W'(DEPTH - 2);

   state_t            state;
   logic              drain_last;
   logic              vld_p1;
   logic [ADDR_W-1:0] addr_p1;

   function automatic logic [SUM_W-1:0] acc_add(input logic [SUM_W-1:0] acc,
                                                input logic [DATA_W-1:0] word);
      return acc + SUM_W'(word);
   endfunction

   // Stage p1: address that was presented to the RAM one cycle earlier
   always_ff @(posedge clock) begin
      addr_p1 <= ram_addr;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         drain_last <= 1'b0;
         vld_p1     <= 1'b0;
         ram_data   <= '0;
         ram_addr   <= '0;
         ram_we     <= 1'b0;
         busy       <= 1'b0;
         rd_valid   <= 1'b0;
         rd_addr    <= '0;
         rd_data    <= '0;
         sum        <= '0;
         done       <= 1'b0;
      end else begin
         // Output stage: ram_q now carries the word addressed two cycles ago
         vld_p1   <= (state == SCAN);
         rd_valid <= vld_p1;
         if (vld_p1) begin
            rd_addr <= addr_p1;
            rd_data <= ram_q;
            sum     <= acc_add(sum, ram_q);
         end
         done <= 1'b0;

         case (state)
            IDLE: begin
               if (clr_req) begin
                  state    <= CLEAR;
                  busy     <= 1'b1;
                  ram_we   <= 1'b1;
                  ram_addr <= '0;
                  ram_data <= '0;
               end else if (wr_req) begin
                  state    <= WRITE;
                  busy     <= 1'b1;
                  ram_we   <= 1'b1;
                  ram_addr <= wr_addr;
                  ram_data <= wr_data;
               end else if (scan_req) begin
                  state    <= SCAN;
                  busy     <= 1'b1;
                  ram_we   <= 1'b0;
                  ram_addr <= '0;
                  sum      <= '0;
               end
            end
            WRITE: begin
               state  <= IDLE;
               busy   <= 1'b0;
               ram_we <= 1'b0;
            end
            CLEAR: begin
               if (ram_addr == LAST_ADDR) begin
                  state  <= IDLE;
                  busy   <= 1'b0;
                  ram_we <= 1'b0;
               end else begin
                  ram_addr <= ram_addr + 1'b1;
                  done     <= (ram_addr == PENULT_ADDR);
               end
            end
            SCAN: begin
               // Hold the last address rather than wrapping back to 0
               if (ram_addr == LAST_ADDR) begin
                  state      <= DRAIN;
                  drain_last <= 1'b0;
               end else begin
                  ram_addr <= ram_addr + 1'b1;
               end
            end
            DRAIN: begin
               if (!drain_last) begin
                  drain_last <= 1'b1;
                  done       <= 1'b1;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
